// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RISC-V core datapath: the ALU operation
// enum and the load/store unit state type, funct3 access codes and the small
// decode helpers the load/store unit uses at request accept.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   // funct3 access size/sign codes shared by loads and stores
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   // True when funct3 names a real access for the given direction.
   function automatic logic lsu_funct3_legal(input logic [2:0] funct3, input logic is_store);
      logic legal;
      case (funct3)
         LSU_B, LSU_H, LSU_W: legal = 1'b1;
         LSU_BU, LSU_HU:      legal = !is_store;
         default:             legal = 1'b0;
      endcase
      return legal;
   endfunction

   // True when the address is not naturally aligned for the access size.
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      case (funct3)
         LSU_H, LSU_HU: mis = offset[0];
         LSU_W:         mis = (offset != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane logic for the load/store unit.
//   Store side: byte enables and lane-replicated store data from the access
//               size and the low address bits of the incoming request.
//   Load side : lane select from the returned bus word and sign/zero extension.
// Ports:
//   st_size   [1:0]  in  : funct3[1:0] of the request (00 byte, 01 half, else word)
//   st_offset [1:0]  in  : addr[1:0] of the request
//   st_data   [31:0] in  : store data (rs2)
//   be        [3:0]  out : bus byte enables
//   st_lanes  [31:0] out : replicated store data
//   ld_funct3 [2:0]  in  : registered funct3 of the load
//   ld_offset [1:0]  in  : registered addr[1:0] of the load
//   ld_word   [31:0] in  : raw bus read word
//   ld_data   [31:0] out : extended load result
// Low address bits that do not fit the access size are ignored (half uses
// addr[1] only, word uses lane 0).
// -----------------------------------------------------------------------------
module lsu_align
   import core_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] st_lanes,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Byte enables and store lane replication.
   always_comb begin
      be       = 4'b0000;
      st_lanes = 32'h0000_0000;
      case (st_size)
         2'b00: begin
            be       = 4'b0001 << st_offset;
            st_lanes = {4{st_data[7:0]}};
         end
         2'b01: begin
            be       = 4'b0011 << {st_offset[1], 1'b0};
            st_lanes = {2{st_data[15:0]}};
         end
         default: begin
            be       = 4'b1111;
            st_lanes = st_data;
         end
      endcase
   end

   // Load lane select and extension.
   always_comb begin
      ld_byte = 8'h00;
      ld_half = 16'h0000;
      ld_data = 32'h0000_0000;
      case (ld_offset)
         2'b00:   ld_byte = ld_word[7:0];
         2'b01:   ld_byte = ld_word[15:8];
         2'b10:   ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      if (ld_offset[1]) begin
         ld_half = ld_word[31:16];
      end else begin
         ld_half = ld_word[15:0];
      end
      case (ld_funct3)
         LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LSU_BU:  ld_data = {24'h00_0000, ld_byte};
         LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
         LSU_HU:  ld_data = {16'h0000, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store unit behind the ALU. Accepts one memory op at a time,
// runs a valid/grant/rvalid transaction on the data bus, aligns byte lanes,
// extends load data and flags illegal ops and response timeouts.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half
// and word accesses are rejected with err_o and never reach the bus; when not
// defined the offending low address bits are ignored.
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in REQ+WAIT before a bus error (0 = never)
//   CNT_W          : timeout counter width (TIMEOUT_CYCLES < 2**CNT_W)
// Ports:
//   clk_i, rst_i (async, active high)
//   req_valid_i, mem_read_i, mem_write_i, funct3_i[2:0], addr_i[31:0], wdata_i[31:0]
//   busy_o, done_o, rdata_o[31:0], err_o                (core side, registered)
//   mem_req_o, mem_we_o, mem_addr_o[31:0], mem_be_o[3:0], mem_wdata_o[31:0]
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i[31:0]          (data-memory bus)
// -----------------------------------------------------------------------------
module load_store_unit
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   // Last counter value before the timeout fires; only meaningful when enabled.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   lsu_state_e        state;
   logic              req_is_load;
   logic [2:0]        req_funct3;
   logic [1:0]        req_offset;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              start;
   logic              accept_err;
   logic              timeout_hit;
   logic [3:0]        be;
   logic [31:0]       st_lanes;
   logic [31:0]       ld_data;

   // Store side is fed from the live request so the bus fields are ready in
   // the first REQ cycle; load side uses the registered request.
   lsu_align u_align (
      .st_size   (funct3_i[1:0]),
      .st_offset (addr_i[1:0]),
      .st_data   (wdata_i),
      .be        (be),
      .st_lanes  (st_lanes),
      .ld_funct3 (req_funct3),
      .ld_offset (req_offset),
      .ld_word   (mem_rdata_i),
      .ld_data   (ld_data)
   );

   // Request acceptance and accept-time error decode.
   always_comb begin
      start      = req_valid_i && (mem_read_i || mem_write_i);
`ifdef LSU_MISALIGN_TRAP_EN
      accept_err = (mem_read_i && mem_write_i)
                   || !lsu_funct3_legal(funct3_i, mem_write_i)
                   || lsu_misaligned(funct3_i, addr_i[1:0]);
`else
      accept_err = (mem_read_i && mem_write_i)
                   || !lsu_funct3_legal(funct3_i, mem_write_i);
`endif
   end

   // Timeout detect and saturating counter increment.
   always_comb begin
      if (TIMEOUT_CYCLES != 0) begin
         timeout_hit = (cnt >= CNT_LAST);
      end else begin
         timeout_hit = 1'b0;
      end
      if (cnt == CNT_MAX) begin
         cnt_next = cnt;
      end else begin
         cnt_next = cnt + CNT_ONE;
      end
   end

   // Transaction FSM with registered core and bus outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= LSU_IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= 32'h0000_0000;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'h0000_0000;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= 32'h0000_0000;
         req_is_load <= 1'b0;
         req_funct3  <= 3'b000;
         req_offset  <= 2'b00;
         cnt         <= {CNT_W{1'b0}};
      end else begin
         case (state)
            LSU_IDLE: begin
               if (start) begin
                  busy_o      <= 1'b1;
                  rdata_o     <= 32'h0000_0000;
                  req_is_load <= mem_read_i;
                  req_funct3  <= funct3_i;
                  req_offset  <= addr_i[1:0];
                  cnt         <= {CNT_W{1'b0}};
                  if (accept_err) begin
                     state  <= LSU_DONE;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else begin
                     state       <= LSU_REQ;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= mem_write_i;
                     mem_addr_o  <= {addr_i[31:2], 2'b00};
                     mem_be_o    <= be;
                     mem_wdata_o <= st_lanes;
                  end
               end
            end
            LSU_REQ: begin
               cnt <= cnt_next;
               // A grant in the timeout cycle still completes the handshake.
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (req_is_load) begin
                     state <= LSU_WAIT;
                  end else begin
                     state  <= LSU_DONE;
                     done_o <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  state     <= LSU_DONE;
                  done_o    <= 1'b1;
                  err_o     <= 1'b1;
               end
            end
            LSU_WAIT: begin
               cnt <= cnt_next;
               // Data arriving in the timeout cycle wins over the error.
               if (mem_rvalid_i) begin
                  rdata_o <= ld_data;
                  state   <= LSU_DONE;
                  done_o  <= 1'b1;
               end else if (timeout_hit) begin
                  rdata_o <= 32'h0000_0000;
                  state   <= LSU_DONE;
                  done_o  <= 1'b1;
                  err_o   <= 1'b1;
               end
            end
            LSU_DONE: begin
               state  <= LSU_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
               err_o  <= 1'b0;
            end
            default: begin
               state     <= LSU_IDLE;
               busy_o    <= 1'b0;
               done_o    <= 1'b0;
               err_o     <= 1'b0;
               mem_req_o <= 1'b0;
               mem_we_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   logic        t_busy, t_done, t_err, t_mem_req, t_mem_we;
   logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
   logic [3:0]  t_mem_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_read_i(mem_read),
      .mem_write_i(mem_write), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
      .busy_o(busy), .done_o(done), .rdata_o(rdata), .err_o(err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata)
   );

   // Short-timeout instance, checked only in the timeout sequence.
   load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut_to (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_read_i(mem_read),
      .mem_write_i(mem_write), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
      .busy_o(t_busy), .done_o(t_done), .rdata_o(t_rdata), .err_o(t_err),
      .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_be_o(t_mem_be),
      .mem_wdata_o(t_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      string       name;
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, wd, word;
      int          gd, rdl;
      logic        e_err;
      int          e_done;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wdata, e_rdata;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                               input int gd, input int rdl, input logic e_err, input int e_done,
                               input logic [3:0] e_be, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata, input logic [31:0] e_rdata);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.word = word;
      v.gd = gd; v.rdl = rdl; v.e_err = e_err; v.e_done = e_done; v.e_be = e_be;
      v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
      return v;
   endfunction

   // Reference model: expectations from the access rules, by plain arithmetic.
   function automatic vec_t model(input vec_t v);
      int nbytes, lo, off;
      logic legal;
      longint unsigned val, mask;
      legal = (v.rd != v.wr);
      if (v.wr) legal = legal && (v.f3 <= 3'd2);
      else      legal = legal && (v.f3 <= 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
      nbytes = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      lo  = int'(v.a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((lo % nbytes) != 0) legal = 1'b0;
`endif
      off = (lo / nbytes) * nbytes;
      v.e_err   = !legal;
      v.e_done  = !legal ? 1 : (v.wr ? v.gd + 2 : v.gd + v.rdl + 3);
      v.e_be    = 4'(((1 << nbytes) - 1) << off);
      v.e_addr  = v.a & 32'hFFFF_FFFC;
      v.e_wdata = (nbytes == 1) ? ({24'h0, v.wd[7:0]} * 32'h0101_0101) :
                  (nbytes == 2) ? ({16'h0, v.wd[15:0]} * 32'h0001_0001) : v.wd;
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = (64'(v.word) >> (8 * off)) & mask;
      if (nbytes < 4 && !v.f3[2] && (((val >> (8 * nbytes - 1)) & 64'd1) == 64'd1))
         val = val | (~mask & 64'hFFFF_FFFF);
      v.e_rdata = (legal && v.rd) ? 32'(val) : 32'h0;
      return v;
   endfunction

   // Drive one request, play the memory side, check against the vector.
   task automatic run_vec(input vec_t v);
      int cyc, reqc, gcyc;
      logic seen, got_err, got_we, stable;
      logic [31:0] got_rd, got_addr, got_wd;
      logic [3:0] got_be;
      req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
      funct3 = v.f3; addr = v.a; wdata = v.wd;
      step();
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      cyc = 1; reqc = 0; gcyc = -1; seen = 1'b0; stable = 1'b1;
      got_err = 1'b0; got_we = 1'b0; got_rd = 32'h0; got_addr = 32'h0; got_wd = 32'h0; got_be = 4'h0;
      while (!seen && cyc < 40) begin
         if (done) begin
            seen = 1'b1; got_err = err; got_rd = rdata;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
         end else begin
            if (mem_req) begin
               if (reqc == 0) begin
                  got_we = mem_we; got_addr = mem_addr; got_be = mem_be; got_wd = mem_wdata;
               end else if (got_we !== mem_we || got_addr !== mem_addr || got_be !== mem_be || got_wd !== mem_wdata) begin
                  stable = 1'b0;
               end
               reqc++;
               mem_gnt = (reqc == v.gd + 1);
               if (mem_gnt) gcyc = cyc;
            end else begin
               mem_gnt = 1'b0;
            end
            mem_rvalid = (gcyc >= 0) && (cyc == gcyc + 1 + v.rdl);
            mem_rdata  = mem_rvalid ? v.word : $urandom;
            step();
            cyc++;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s no_done: got none within %0d cycles, required done at %0d", v.name, cyc, v.e_done);
      end else begin
         chk({v.name, " done_cycle"}, 32'(cyc), 32'(v.e_done));
      end
      chk({v.name, " err"}, {31'h0, got_err}, {31'h0, v.e_err});
      if (v.rd && !v.wr) chk({v.name, " rdata"}, got_rd, v.e_rdata);
      if (v.e_err) begin
         chk({v.name, " no_bus"}, 32'(reqc), 32'h0);
      end else begin
         chk({v.name, " req_cycles"}, 32'(reqc), 32'(v.gd + 1));
         chk({v.name, " we"}, {31'h0, got_we}, {31'h0, v.wr});
         chk({v.name, " addr"}, got_addr, v.e_addr);
         chk({v.name, " be"}, {28'h0, got_be}, {28'h0, v.e_be});
         if (v.wr) chk({v.name, " wdata"}, got_wd, v.e_wdata);
         chk({v.name, " bus_stable"}, {31'h0, stable}, 32'h1);
      end
      step();
      chk({v.name, " back_idle"}, {29'h0, busy, done, err}, 32'h0);
   endtask

   initial begin
      int cyc;
      logic tseen;
      vec_t v;

      tbl[0]  = mk("lw",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 3, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
      tbl[1]  = mk("lb",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0, 3, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
      tbl[2]  = mk("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0, 3, 4'b1000, 32'h100, 32'h0, 32'h00000080);
      tbl[3]  = mk("sh",  0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 0, 5, 4'b1100, 32'h200, 32'hABCDABCD, 32'h0);
      tbl[4]  = mk("lh",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, 2, 0, 6, 4'b1100, 32'h100, 32'h0, 32'hFFFF8001);
      tbl[5]  = mk("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 32'h80011234, 0, 0, 0, 3, 4'b0011, 32'h100, 32'h0, 32'h00001234);
      tbl[6]  = mk("sb",  0, 1, 3'b000, 32'h101, 32'h00000055, 32'h0, 0, 0, 0, 2, 4'b0010, 32'h100, 32'h55555555, 32'h0);
      tbl[7]  = mk("sw",  0, 1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1, 0, 0, 3, 4'b1111, 32'h3FC, 32'hCAFEF00D, 32'h0);
      tbl[8]  = mk("ld_f3_011", 1, 0, 3'b011, 32'h10, 32'h0, 32'h12345678, 0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
      tbl[9]  = mk("rd_and_wr", 1, 1, 3'b010, 32'h20, 32'h0, 32'h12345678, 0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
      tbl[10] = mk("st_f3_100", 0, 1, 3'b100, 32'h30, 32'h99, 32'h0, 0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[11] = mk("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
      tbl[12] = mk("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0, 32'hA5B6C7D8, 0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
`else
      tbl[11] = mk("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 0, 3, 4'b1111, 32'h100, 32'h0, 32'h11223344);
      tbl[12] = mk("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0, 32'hA5B6C7D8, 0, 0, 0, 3, 4'b1100, 32'h100, 32'h0, 32'hFFFFA5B6);
`endif

      rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      step(); step();
      chk("reset_ctrl", {27'h0, busy, done, err, mem_req, mem_we}, 32'h0);
      chk("reset_addr", mem_addr, 32'h0);
      chk("reset_be", {28'h0, mem_be}, 32'h0);
      chk("reset_wdata", mem_wdata, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_to_ctrl", {27'h0, t_busy, t_done, t_err, t_mem_req, t_mem_we}, 32'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 13; i++) run_vec(tbl[i]);

      for (int i = 0; i < 80; i++) begin
         v.name = $sformatf("rand%0d", i);
         v.rd = 1'($urandom_range(0, 1));
         v.wr = !v.rd;
         if ($urandom_range(0, 9) == 0) begin v.rd = 1'b1; v.wr = 1'b1; end
         if ($urandom_range(0, 4) == 0) v.f3 = 3'($urandom_range(0, 7));
         else if (v.wr)                 v.f3 = 3'($urandom_range(0, 2));
         else                           v.f3 = 3'($urandom_range(0, 4)) + (($urandom_range(0, 4) >= 3) ? 3'd3 : 3'd0);
         if (v.f3 == 3'd6 || v.f3 == 3'd7) v.f3 = v.f3 - 3'd2;
         v.a = $urandom; v.wd = $urandom; v.word = $urandom;
         v.gd = $urandom_range(0, 3); v.rdl = $urandom_range(0, 3);
         run_vec(model(v));
      end

      // Timeout: short-timeout instance, load granted at once, no rvalid.
      req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
      step();
      req_valid = 1'b0; mem_read = 1'b0;
      cyc = 1; tseen = 1'b0;
      while (!tseen && cyc < 20) begin
         if (t_done) begin
            tseen = 1'b1;
            chk("to_err", {31'h0, t_err}, 32'h1);
            chk("to_rdata", t_rdata, 32'h0);
            chk("to_req_dropped", {31'h0, t_mem_req}, 32'h0);
            mem_gnt = 1'b0;
         end else begin
            mem_gnt = t_mem_req; mem_rvalid = 1'b0; mem_rdata = $urandom;
            step();
            cyc++;
         end
      end
      total++;
      if (!tseen) begin
         bad++;
         $display("FAIL to_no_done: got none within %0d cycles, required done at 5", cyc);
      end else begin
         chk("to_done_cycle", 32'(cyc), 32'd5);
      end
      step();
      chk("to_busy_fall", {30'h0, t_busy, t_done}, 32'h0);
      chk("long_timeout_still_waiting", {30'h0, busy, mem_req}, 32'h2);

      // Reset while the default instance sits in WAIT.
      #2 rst = 1'b1;
      #1;
      chk("rst_wait_busy", {30'h0, busy, mem_req}, 32'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5; mem_gnt = 1'b1;
         step();
         chk("late_rvalid_ignored", {29'h0, busy, done, err}, 32'h0);
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      step();

      // Reset while a store is holding its request.
      req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h80; wdata = 32'h1;
      step();
      req_valid = 1'b0; mem_write = 1'b0;
      chk("req_before_rst", {30'h0, mem_req, mem_we}, 32'h3);
      #2 rst = 1'b1;
      #1;
      chk("rst_req_drop", {29'h0, busy, mem_req, mem_we}, 32'h0);
      step();
      rst = 1'b0;
      step();

      run_vec(tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address and rs2 as store data, and runs a valid/grant/rvalid transaction on the data-memory bus. It performs byte-lane alignment, load sign/zero extension, alignment checking and a response timeout. The core stalls on `busy_o` and writes back `rdata_o` on `done_o`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: max cycles spent in REQ+WAIT before a bus error is flagged; 0 disables the timeout.
- `CNT_W`, default 8: width of the timeout counter; must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `req_valid_i` input 1: core requests a memory op this cycle.
- `mem_read_i` input 1: load.
- `mem_write_i` input 1: store. Both read and write high = illegal, flags error.
- `funct3_i` input 3: access size/sign.
- `addr_i` input 32: effective address, from ALU `alu_result_o`.
- `wdata_i` input 32: store data (rs2).
- `busy_o` output 1: unit not idle; core stalls.
- `done_o` output 1: one-cycle completion pulse.
- `rdata_o` output 32: extended load data, valid with `done_o`.
- `err_o` output 1: one-cycle pulse with `done_o` on misalign/illegal/timeout.
- `mem_req_o` output 1: bus request.
- `mem_we_o` output 1: bus write enable.
- `mem_addr_o` output 32: word-aligned address (`[1:0]=0`).
- `mem_be_o` output 4: byte enables.
- `mem_wdata_o` output 32: lane-replicated store data.
- `mem_gnt_i` input 1: bus accepted request.
- `mem_rvalid_i` input 1: read data valid.
- `mem_rdata_i` input 32: read data word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE.** On `req_valid_i && (mem_read_i || mem_write_i)`, register addr, wdata, funct3 and direction, then go to REQ. Inputs are ignored outside IDLE.
- **Legal funct3.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code, or read && write: skip the bus, go to DONE with `err_o`.
- **REQ.** Hold `mem_req_o`=1 with stable addr/we/be/wdata until `mem_gnt_i`. Then a store goes to DONE and a load goes to WAIT.
- **WAIT.** On `mem_rvalid_i`, capture and extend the data, then go to DONE.
- **DONE.** `done_o`=1 for one cycle, then go to IDLE.
- **Byte enables.**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
- **Store data.** Byte is replicated ×4; half is replicated ×2; word is passed through.
- **Load data.** Select the lane by `addr[1:0]`. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **Timeout.** The counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches `TIMEOUT_CYCLES`: go to DONE with `err_o`, `rdata_o`=0, `mem_req_o` dropped.
  - `mem_rvalid_i` in the same cycle as the timeout wins: no error.
- Loads that end in error return `rdata_o`=0.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `err_o`, `mem_req_o`, `mem_we_o` = 0; `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `rdata_o` = 0.
- Reset mid-transaction returns to IDLE asynchronously; `mem_req_o` falls immediately and any late `mem_rvalid_i` is ignored.
- `busy_o` = (state != IDLE), registered.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle):
  - Load: accept at T0, REQ T1, WAIT T2, `done_o` T3.
  - Store: accept at T0, REQ T1, `done_o` T2.
- Error detected at accept: `done_o`+`err_o` at T1, with no bus activity.
- `mem_rvalid_i` outside WAIT is ignored; `mem_gnt_i` outside REQ is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned half (`addr[0]`) or word (`addr[1:0]!=0`) skips the bus.
  - `done_o`+`err_o` at T1.
- Not defined:
  - No misalign error is raised.
  - The offending low address bits are treated as zero: half uses `addr[1]` only; word uses lane 0.

## Structure
- Shared core package (alongside the ALU op enum):
  - `lsu_state_e`.
  - funct3 constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
- Sub-module `lsu_align` (combinational): byte-enable and store-lane generation, plus load lane select and extension.
- Top level holds the FSM, input registers and timeout counter.

## Test plan
- **LW.** Addr 0x100, `mem_rdata_i`=0xDEADBEEF, zero-wait → `mem_be_o`=1111, `done_o` at T3, `rdata_o`=0xDEADBEEF.
- **LB / LBU.** Addr 0x103, rdata 0x80FFFFFF → LB `rdata_o`=0xFFFFFF80; LBU `rdata_o`=0x00000080.
- **SH.** Addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles → `mem_req_o` held 4 cycles, `mem_be_o`=1100, `mem_wdata_o`=0xABCDABCD, `done_o` 1 cycle after gnt.
- **Timeout.** `TIMEOUT_CYCLES`=4, load granted, rvalid never asserted → `err_o`+`done_o`, `rdata_o`=0, `busy_o` falls next cycle.
- **Misalign.** LW at 0x101:
  - With `LSU_MISALIGN_TRAP_EN`: `err_o` at T1, `mem_req_o` never asserted.
  - Without it: `mem_addr_o`=0x100, `mem_be_o`=1111.
- **Reset mid-WAIT.** `rst_i` pulsed during WAIT → `busy_o`/`mem_req_o` low immediately; a later rvalid produces no `done_o`.
